// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch redirect logic and its neighbours.
//   fetch_state_e    : fetch control FSM encoding (2 bits)
//   PC_INC           : sequential fetch stride
//   DELAY_SLOT_OFF   : offset used by the predictor's not-taken recovery target
//   next_seq_pc()    : sequential successor of a fetch PC (wraps modulo 2^32)
//   not_taken_target(): recovery PC for a branch resolved not-taken
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_SQUASH = 2'd2,
        S_HOLD   = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_INC         = 32'd4;
    localparam logic [31:0] DELAY_SLOT_OFF = 32'd8;

    // Plain 32-bit addition; carry out is dropped so 32'hFFFF_FFFC wraps to 0.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

    function automatic logic [31:0] not_taken_target(input logic [31:0] pc);
        return pc + DELAY_SLOT_OFF;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// CNT_W-bit up counter that sticks at all-ones instead of wrapping.
//   clk   in  : clock, rising edge
//   clr   in  : synchronous clear, dominates inc
//   inc   in  : count request for this cycle
//   count out : registered count value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear first, then increment only while below the ceiling.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CNT_W{1'b0}};
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// fetch_redirect_unit
// Owns the fetch PC, steers it from the branch predictor's redirect request,
// carries each fetched PC and its predicted direction into the IF/ID slot and
// reflects decoder branch resolution back to the predictor.
//
// Ports
//   CLK, RESET               : clock; synchronous active-high reset
//   STALL                    : freeze PC, IF/ID slot and FSM
//   take_Branch_IN / take_Alt_PC_IN : predictor redirect request and target
//   FLUSH_IN                 : predictor mispredict flag (squash next ID slot)
//   dec_is_Branch_IN / dec_is_Taken_IN / dec_Target_IN : decoder resolution
//   Instr_PC_OUT_IF          : current fetch PC
//   Instr_PC_OUT_ID          : PC held in the IF/ID slot
//   ID_Valid_OUT             : IF/ID slot holds a live instruction
//   is_Branch_OUT_ID / is_Taken_OUT_ID / Alt_PC_OUT_ID : gated resolution
//   Branch_Count_OUT / Mispred_Count_OUT : saturating statistics
// ---------------------------------------------------------------------------
module fetch_redirect_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic             take_Branch_IN,
    input  logic [31:0]      take_Alt_PC_IN,
    input  logic             FLUSH_IN,
    input  logic             dec_is_Branch_IN,
    input  logic             dec_is_Taken_IN,
    input  logic [31:0]      dec_Target_IN,
    output logic [31:0]      Instr_PC_OUT_IF,
    output logic [31:0]      Instr_PC_OUT_ID,
    output logic             ID_Valid_OUT,
    output logic             is_Branch_OUT_ID,
    output logic             is_Taken_OUT_ID,
    output logic [31:0]      Alt_PC_OUT_ID,
    output logic [CNT_W-1:0] Branch_Count_OUT,
    output logic [CNT_W-1:0] Mispred_Count_OUT
);

    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  id_pc_q;
    logic [31:0]  id_pc_d;
    logic         id_valid_q;
    logic         id_valid_d;
    logic         pred_q;
    logic         pred_d;
    fetch_state_e state_q;
    fetch_state_e state_d;

    logic         id_branch_s;
    logic         count_en_s;
    logic         mispred_s;

    // ID-side view: everything drops to 0 while the slot is empty so the
    // predictor sees clean edges on is_Taken between live branches.
    always_comb begin
        id_branch_s = id_valid_q & dec_is_Branch_IN;
        if (id_branch_s) begin
            is_Taken_OUT_ID = dec_is_Taken_IN;
            Alt_PC_OUT_ID   = dec_Target_IN;
        end else begin
            is_Taken_OUT_ID = 1'b0;
            Alt_PC_OUT_ID   = 32'h0000_0000;
        end
    end

    assign is_Branch_OUT_ID = id_branch_s;
    assign Instr_PC_OUT_IF  = pc_q;
    assign Instr_PC_OUT_ID  = id_pc_q;
    assign ID_Valid_OUT     = id_valid_q;

    // PC steering and IF/ID advance. Redirect requests (and flushes) are
    // ignored entirely while stalled. The boot bubble is the invalid slot
    // loaded by reset; the instruction fetched at RESET_PC enters ID live.
    always_comb begin
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        pred_d     = pred_q;
        if (STALL) begin
            pc_d       = pc_q;
            id_pc_d    = id_pc_q;
            id_valid_d = id_valid_q;
            pred_d     = pred_q;
        end else begin
            if (take_Branch_IN) begin
                pc_d = take_Alt_PC_IN;
            end else begin
                pc_d = next_seq_pc(pc_q);
            end
            id_pc_d = pc_q;
            // A flush redirect is a recovery, not a prediction of this slot.
            pred_d  = take_Branch_IN & ~FLUSH_IN;
            if (FLUSH_IN) begin
                id_valid_d = 1'b0;
            end else begin
                id_valid_d = 1'b1;
            end
        end
    end

    // Fetch control FSM next state. S_SQUASH marks the cycle whose ID slot is
    // the flush bubble; a further flush there simply re-enters S_SQUASH.
    // Leaving S_HOLD behaves like the running state it froze: the pending
    // slot (live or bubble) advances on release, so S_RUN is the next state
    // unless a new flush arrives on that same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: begin
                if (STALL) begin
                    state_d = S_BOOT;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN, S_SQUASH, S_HOLD: begin
                if (STALL) begin
                    state_d = S_HOLD;
                end else if (FLUSH_IN) begin
                    state_d = S_SQUASH;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State registers; reset dominates STALL and FLUSH_IN.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= 32'h0000_0000;
            id_valid_q <= 1'b0;
            pred_q     <= 1'b0;
            state_q    <= S_BOOT;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
            pred_q     <= pred_d;
            state_q    <= state_d;
        end
    end

    // Statistics only move on cycles where the ID slot actually retires.
    always_comb begin
        count_en_s = ~STALL & id_branch_s;
        mispred_s  = count_en_s & (pred_q != dec_is_Taken_IN);
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_branch_cnt (
        .clk   (CLK),
        .clr   (RESET),
        .inc   (count_en_s),
        .count (Branch_Count_OUT)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_mispred_cnt (
        .clk   (CLK),
        .clr   (RESET),
        .inc   (mispred_s),
        .count (Mispred_Count_OUT)
    );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_redirect_unit
// Directed bench for fetch_redirect_unit. Two instances share the stimulus:
// a 32-bit-counter instance and a 4-bit-counter instance for saturation.
// A transaction-level model tracks fetch PC, IF/ID slot and branch totals;
// outputs are compared against it every cycle, plus literal spot checks.
// ---------------------------------------------------------------------------
module tb_fetch_redirect_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        tb;
    logic        fl;
    logic        dbr;
    logic        dtk;
    logic [31:0] alt;
    logic [31:0] tgt;

    logic [31:0] w_if, w_id, w_alt;
    logic        w_valid, w_br, w_tk;
    logic [31:0] w_bc, w_mc;
    logic [31:0] n_if, n_id, n_alt;
    logic        n_valid, n_br, n_tk;
    logic [3:0]  n_bc, n_mc;

    int checks = 0;
    int errors = 0;

    fetch_redirect_unit #(.RESET_PC(32'h0000_1000), .CNT_W(32)) u_wide (
        .CLK(clk), .RESET(rst), .STALL(stall),
        .take_Branch_IN(tb), .take_Alt_PC_IN(alt), .FLUSH_IN(fl),
        .dec_is_Branch_IN(dbr), .dec_is_Taken_IN(dtk), .dec_Target_IN(tgt),
        .Instr_PC_OUT_IF(w_if), .Instr_PC_OUT_ID(w_id), .ID_Valid_OUT(w_valid),
        .is_Branch_OUT_ID(w_br), .is_Taken_OUT_ID(w_tk), .Alt_PC_OUT_ID(w_alt),
        .Branch_Count_OUT(w_bc), .Mispred_Count_OUT(w_mc)
    );

    fetch_redirect_unit #(.RESET_PC(32'h0000_1000), .CNT_W(4)) u_narrow (
        .CLK(clk), .RESET(rst), .STALL(stall),
        .take_Branch_IN(tb), .take_Alt_PC_IN(alt), .FLUSH_IN(fl),
        .dec_is_Branch_IN(dbr), .dec_is_Taken_IN(dtk), .dec_Target_IN(tgt),
        .Instr_PC_OUT_IF(n_if), .Instr_PC_OUT_ID(n_id), .ID_Valid_OUT(n_valid),
        .is_Branch_OUT_ID(n_br), .is_Taken_OUT_ID(n_tk), .Alt_PC_OUT_ID(n_alt),
        .Branch_Count_OUT(n_bc), .Mispred_Count_OUT(n_mc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input int v, input int w);
        longint mx;
        mx = (64'sd1 <<< w) - 64'sd1;
        if (longint'(v) > mx) return mx[31:0];
        else return v[31:0];
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_id;
    bit          m_valid, m_pred;
    bit          m_live = 1'b0;
    int          m_b, m_m;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0000_1000; m_id = 32'd0;
            m_valid = 1'b0; m_pred = 1'b0;
            m_b = 0; m_m = 0; m_live = 1'b1;
        end else if (m_live && !stall) begin
            if (m_valid && dbr) begin
                m_b++;
                if (m_pred != dtk) m_m++;
            end
            m_id    = m_pc;
            m_pred  = tb && !fl;
            m_valid = !fl;
            m_pc    = tb ? alt : m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            bit br;
            br = m_valid && dbr;
            chk("if_pc",     w_if,                m_pc);
            chk("id_pc",     w_id,                m_id);
            chk("id_valid",  {31'd0, w_valid},    {31'd0, m_valid});
            chk("is_branch", {31'd0, w_br},       {31'd0, br});
            chk("is_taken",  {31'd0, w_tk},       {31'd0, br && dtk});
            chk("alt_pc",    w_alt,               br ? tgt : 32'd0);
            chk("br_cnt",    w_bc,                sat(m_b, 32));
            chk("mp_cnt",    w_mc,                sat(m_m, 32));
            chk("n_if_pc",   n_if,                m_pc);
            chk("n_br_cnt",  {28'd0, n_bc},       sat(m_b, 4));
            chk("n_mp_cnt",  {28'd0, n_mc},       sat(m_m, 4));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; stall = 1'b0; tb = 1'b0; fl = 1'b0;
        dbr = 1'b0; dtk = 1'b0; alt = 32'd0; tgt = 32'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_pc",    w_if, 32'h0000_1000);
        chk("rst_valid", {31'd0, w_valid}, 32'd0);
        chk("rst_id",    w_id, 32'd0);
        chk("rst_bc",    w_bc, 32'd0);
        chk("rst_mc",    w_mc, 32'd0);
        tick();
        chk("seq1_pc", w_if, 32'h0000_1004);
        chk("seq1_valid", {31'd0, w_valid}, 32'd1);
        chk("seq1_id", w_id, 32'h0000_1000);
        tick();
        chk("seq2_pc", w_if, 32'h0000_1008);

        // predicted-taken redirect
        tb = 1'b1; alt = 32'h0000_2000;
        tick();
        chk("redir_pc", w_if, 32'h0000_2000);
        chk("redir_id", w_id, 32'h0000_1008);
        tb = 1'b0; dbr = 1'b1; dtk = 1'b1; tgt = 32'h0000_2100;
        #1;
        chk("redir_tk", {31'd0, w_tk}, 32'd1);
        chk("redir_alt", w_alt, 32'h0000_2100);
        tick();
        chk("redir_pc2", w_if, 32'h0000_2004);
        chk("pred_ok_bc", w_bc, 32'd1);
        chk("pred_ok_mc", w_mc, 32'd0);

        // flush with one bubble
        dbr = 1'b0; tb = 1'b1; fl = 1'b1; alt = 32'h0000_3008;
        tick();
        chk("fl_pc", w_if, 32'h0000_3008);
        chk("fl_valid", {31'd0, w_valid}, 32'd0);
        tb = 1'b0; fl = 1'b0; dbr = 1'b1; dtk = 1'b1; tgt = 32'h0000_3333;
        #1;
        chk("fl_tk", {31'd0, w_tk}, 32'd0);
        chk("fl_alt", w_alt, 32'd0);
        tick();
        chk("fl_valid2", {31'd0, w_valid}, 32'd1);
        chk("fl_id", w_id, 32'h0000_3008);
        chk("fl_bc", w_bc, 32'd1);
        dbr = 1'b0;

        // back-to-back flush: latest target wins
        tb = 1'b1; fl = 1'b1; alt = 32'h0000_6000;
        tick();
        alt = 32'h0000_7000;
        tick();
        chk("fl2_pc", w_if, 32'h0000_7000);
        chk("fl2_valid", {31'd0, w_valid}, 32'd0);
        tb = 1'b0; fl = 1'b0;
        tick();
        chk("fl2_id", w_id, 32'h0000_7000);
        chk("fl2_valid2", {31'd0, w_valid}, 32'd1);

        // stall with redirect/flush activity
        stall = 1'b1; dbr = 1'b1; dtk = 1'b1; tgt = 32'h0000_4444; alt = 32'hDEAD_0000;
        for (int i = 0; i < 3; i++) begin
            tb = (i != 1);
            fl = (i == 2);
            tick();
            chk("stall_pc", w_if, 32'h0000_7004);
            chk("stall_id", w_id, 32'h0000_7000);
            chk("stall_bc", w_bc, 32'd1);
        end
        stall = 1'b0; tb = 1'b0; fl = 1'b0; dbr = 1'b0;
        tick();
        chk("unstall_pc", w_if, 32'h0000_7008);
        chk("unstall_id", w_id, 32'h0000_7004);

        // mispredict: stored prediction 0, resolved taken
        dbr = 1'b1; dtk = 1'b1; tgt = 32'h0000_4000;
        #1;
        chk("mp_tk", {31'd0, w_tk}, 32'd1);
        chk("mp_alt", w_alt, 32'h0000_4000);
        tick();
        chk("mp_bc", w_bc, 32'd2);
        chk("mp_mc", w_mc, 32'd1);
        dbr = 1'b0;

        // PC wrap
        tb = 1'b1; alt = 32'hFFFF_FFFC;
        tick();
        chk("wrap_pc0", w_if, 32'hFFFF_FFFC);
        tb = 1'b0;
        tick();
        chk("wrap_pc1", w_if, 32'h0000_0000);

        // 16 further mispredicts: 4-bit counters pin at F
        dbr = 1'b1; dtk = 1'b1;
        repeat (16) tick();
        chk("sat_n_mc", {28'd0, n_mc}, 32'h0000_000F);
        chk("sat_n_bc", {28'd0, n_bc}, 32'h0000_000F);
        chk("sat_w_mc", w_mc, 32'd17);
        chk("sat_w_bc", w_bc, 32'd18);
        dbr = 1'b0;

        // reset beats stall and flush
        rst = 1'b1; stall = 1'b1; fl = 1'b1; tb = 1'b1;
        tick();
        chk("rst2_pc", w_if, 32'h0000_1000);
        chk("rst2_valid", {31'd0, w_valid}, 32'd0);
        chk("rst2_bc", w_bc, 32'd0);
        chk("rst2_n_mc", {28'd0, n_mc}, 32'd0);
        rst = 1'b0; stall = 1'b0; fl = 1'b0; tb = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
